// File: rtl/core_pkg.sv
// core_pkg: shared instruction-format constants and types for the 16-bit core
package core_pkg;
  localparam int INSTR_WIDTH = 16;
  localparam int REG_ADDR_W = 3;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  typedef logic [INSTR_WIDTH-1:0] instr_t;
  localparam instr_t NOP_INSTR = 16'h0000;
endpackage

// File: rtl/if_id_stage_if.sv
// if_id_stage_if: instruction memory bus between the fetch stage (master) and imem (slave)
interface if_id_stage_if #(
  parameter int PC_WIDTH = 8,
  parameter int INSTR_WIDTH = 16
);
  logic [PC_WIDTH-1:0] imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  modport master (output imem_addr, input imem_rdata);
  modport slave (input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_id_stage_pc_reg.sv
// pc_reg: fetch PC with redirect, stall hold and wrapping increment
module pc_reg #(
  parameter int PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pc_write,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc
);
  always_ff @(posedge clk)
    if (!rst_n) pc <= RESET_PC;
    else if (redirect) pc <= target;
    else if (pc_write) pc <= pc + PC_WIDTH'(1);
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: fetch PC plus IF/ID register; IF_PERF_CNT_EN adds stall/flush counters
import core_pkg::*;
module if_id_stage #(
  parameter int PC_WIDTH = 8,
  parameter int INSTR_WIDTH = core_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pc_write,
  input  logic                   if_id_write,
  input  logic                   ex_branch_taken,
  input  logic [PC_WIDTH-1:0]    ex_branch_target,
  if_id_stage_if.master          imem,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic                   if_id_valid,
  output logic [REG_ADDR_W-1:0]  if_id_rd,
  output logic [REG_ADDR_W-1:0]  if_id_rs1,
  output logic [REG_ADDR_W-1:0]  if_id_rs2
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]            stall_cnt,
  output logic [15:0]            flush_cnt
`endif
);
  pc_reg #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst_n(rst_n),
    .pc_write(pc_write),
    .redirect(ex_branch_taken),
    .target(ex_branch_target),
    .pc(pc)
  );
  assign imem.imem_addr = pc;
  // a redirect beats a stall: whatever is held is on the wrong path
  always_ff @(posedge clk)
    if (!rst_n) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc <= '0;
      if_id_valid <= 1'b0;
    end else if (ex_branch_taken) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc <= ex_branch_target;
      if_id_valid <= 1'b0;
    end else if (if_id_write) begin
      if_id_instr <= imem.imem_rdata;
      if_id_pc <= pc;
      if_id_valid <= 1'b1;
    end
  assign if_id_rd = if_id_instr[RD_MSB:RD_LSB];
  assign if_id_rs1 = if_id_instr[RS1_MSB:RS1_LSB];
  assign if_id_rs2 = if_id_instr[RS2_MSB:RS2_LSB];
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= (!ex_branch_taken && !pc_write && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
      flush_cnt <= (ex_branch_taken && flush_cnt != 16'hFFFF) ? flush_cnt + 16'd1 : flush_cnt;
    end
`endif
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed stimulus, per-cycle model comparison plus literal checkpoints
module tb_if_id_stage;
  logic clk = 1'b0;
  logic rst_n, pc_write, if_id_write, ex_branch_taken;
  logic [7:0] ex_branch_target, pc, if_id_pc;
  logic [15:0] if_id_instr;
  logic if_id_valid;
  logic [2:0] if_id_rd, if_id_rs1, if_id_rs2;
`ifdef IF_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif
  logic [15:0] mem [256];
  int n_cmp = 0;
  int n_err = 0;
  int m_pc, m_ipc, m_instr, m_valid;
  bit m_live = 0;

  always #5 clk = ~clk;

  if_id_stage_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus ();
  assign bus.imem_rdata = mem[bus.imem_addr];

  if_id_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc_write(pc_write),
    .if_id_write(if_id_write),
    .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target),
    .imem(bus),
    .pc(pc),
    .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid),
    .if_id_rd(if_id_rd),
    .if_id_rs1(if_id_rs1),
    .if_id_rs2(if_id_rs2)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 0; m_ipc = 0; m_instr = 0; m_valid = 0; m_live = 1;
    end else if (ex_branch_taken) begin
      m_pc = ex_branch_target; m_ipc = ex_branch_target; m_instr = 0; m_valid = 0;
    end else begin
      if (if_id_write) begin
        m_instr = mem[m_pc]; m_ipc = m_pc; m_valid = 1;
      end
      if (pc_write) m_pc = (m_pc + 1) % 256;
    end
    #1;
    if (m_live) begin
      chk("model_pc", 32'(pc), 32'(m_pc));
      chk("model_imem_addr", 32'(bus.imem_addr), 32'(m_pc));
      chk("model_instr", 32'(if_id_instr), 32'(m_instr));
      chk("model_if_id_pc", 32'(if_id_pc), 32'(m_ipc));
      chk("model_valid", 32'(if_id_valid), 32'(m_valid));
      chk("model_rd", 32'(if_id_rd), 32'((m_instr >> 9) & 7));
      chk("model_rs1", 32'(if_id_rs1), 32'((m_instr >> 6) & 7));
      chk("model_rs2", 32'(if_id_rs2), 32'((m_instr >> 3) & 7));
    end
  end

  task automatic drive(input logic r, input logic pw, input logic iw, input logic br, input logic [7:0] tg);
    rst_n = r; pc_write = pw; if_id_write = iw; ex_branch_taken = br; ex_branch_target = tg;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'h1234;
    mem[4] = 16'h0A58;
    drive(0, 1, 1, 0, 8'h00);
    step(2);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_instr", 32'(if_id_instr), 32'h0);
    chk("rst_fields", {if_id_rd, if_id_rs1, if_id_rs2}, 32'h0);
    chk("rst_rdata", 32'(bus.imem_rdata), 32'h1234);
    drive(1, 1, 1, 0, 8'h00);
    step(1);
    chk("first_instr", 32'(if_id_instr), 32'h1234);
    chk("first_if_id_pc", 32'(if_id_pc), 32'h0);
    chk("first_pc", 32'(pc), 32'h1);
    step(2);
    chk("run_instr", 32'(if_id_instr), 32'h1002);
    chk("run_if_id_pc", 32'(if_id_pc), 32'h2);
    chk("run_pc", 32'(pc), 32'h3);
    drive(1, 0, 0, 0, 8'h00);
    step(2);
    chk("stall_pc", 32'(pc), 32'h3);
    chk("stall_instr", 32'(if_id_instr), 32'h1002);
    chk("stall_if_id_pc", 32'(if_id_pc), 32'h2);
    drive(1, 1, 1, 0, 8'h00);
    step(1);
    chk("release_pc", 32'(pc), 32'h4);
    chk("release_if_id_pc", 32'(if_id_pc), 32'h3);
    step(1);
    chk("decode_fields", {if_id_rd, if_id_rs1, if_id_rs2}, {3'd5, 3'd1, 3'd3});
    drive(1, 0, 0, 1, 8'h40);
    step(1);
    chk("redir_pc", 32'(pc), 32'h40);
    chk("redir_valid", 32'(if_id_valid), 32'h0);
    chk("redir_instr", 32'(if_id_instr), 32'h0);
    drive(1, 1, 1, 0, 8'h00);
    step(1);
    chk("post_redir_if_id_pc", 32'(if_id_pc), 32'h40);
    chk("post_redir_pc", 32'(pc), 32'h41);
    chk("post_redir_instr", 32'(if_id_instr), 32'h1040);
    drive(1, 1, 1, 1, 8'hFF);
    step(1);
    drive(1, 1, 1, 0, 8'h00);
    step(1);
    chk("wrap_pc", 32'(pc), 32'h0);
    chk("wrap_if_id_pc", 32'(if_id_pc), 32'hFF);
    drive(1, 1, 1, 1, 8'h07);
    step(1);
    drive(0, 0, 0, 0, 8'h00);
    step(1);
    chk("rst_stall_pc", 32'(pc), 32'h0);
    chk("rst_stall_valid", 32'(if_id_valid), 32'h0);
    chk("rst_stall_if_id_pc", 32'(if_id_pc), 32'h0);
    drive(1, 0, 0, 0, 8'h00);
    step(3);
    drive(1, 1, 1, 1, 8'h20);
    step(1);
`ifdef IF_PERF_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd3);
    chk("flush_cnt", 32'(flush_cnt), 32'd1);
`endif
    chk("perf_seq_pc", 32'(pc), 32'h20);
    drive(1, 1, 1, 0, 8'h00);
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch stage and IF/ID pipeline register for the 16-bit, 8-register in-order core.
- Holds the PC, drives the instruction memory address, and captures the instruction plus its PC into the IF/ID register.
- Obeys pc_write and if_id_write from the load-use hazard logic, and the EX-stage branch redirect.
- Exports the IF/ID source-register fields back to the hazard logic and the decode stage.

Parameters:
- PC_WIDTH, 8, width of the word-addressed PC.
- INSTR_WIDTH, 16, instruction width. Field layout assumes 16.
- RESET_PC, 0, PC value loaded at reset.
- NOP_INSTR, 16'h0000, encoding inserted on flush and reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- pc_write  in  1  1 = PC may advance; 0 = hold PC (load-use stall).
- if_id_write  in  1  1 = IF/ID register may load; 0 = hold.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- ex_branch_target  in  PC_WIDTH  redirect target.
- imem_addr  out  PC_WIDTH  instruction memory address, equals pc.
- imem_rdata  in  INSTR_WIDTH  combinational read data for imem_addr.
- pc  out  PC_WIDTH  current fetch PC (registered).
- if_id_instr  out  INSTR_WIDTH  registered instruction.
- if_id_pc  out  PC_WIDTH  PC of if_id_instr.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_rd  out  3  if_id_instr[11:9].
- if_id_rs1  out  3  if_id_instr[8:6].
- if_id_rs2  out  3  if_id_instr[5:3].

Behaviour:
- Reset is clk-synchronous and active-low; reset is the only reset mechanism.
- Reset values: pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0. Field outputs decode from if_id_instr, so each reads 0.
- Instruction format: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] imm/func. Field outputs are pure slices of the register, with no extra latency.
- imem_addr = pc, combinational. The instruction is available in the same cycle, so fetch-to-IF/ID latency is 1 cycle.
- Per-edge priority, highest first:
  1. rst_n=0: reset values.
  2. ex_branch_taken=1: pc <= ex_branch_target; if_id_instr <= NOP_INSTR; if_id_valid <= 0; if_id_pc <= ex_branch_target. The redirect overrides a simultaneous stall (pc_write=0 / if_id_write=0), because the stalled instruction is on the wrong path.
  3. Otherwise the PC and IF/ID update independently:
     - pc <= pc_write ? pc+1 : pc.
     - If if_id_write=1: if_id_instr <= imem_rdata, if_id_pc <= pc, if_id_valid <= 1. If 0: hold all three.
- PC increment wraps modulo 2^PC_WIDTH (8'hFF -> 8'h00). No overflow flag.
- pc_write=0 with if_id_write=1 is legal but unused by the core. It re-latches the same pc/instr.
- Reset asserted mid-stall or mid-redirect wins unconditionally on that edge.
- Bubble insertion into ID/EX (id_ex_flush) is not handled here; it belongs to the ID/EX register.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, add outputs stall_cnt[15:0] and flush_cnt[15:0]:
  - stall_cnt increments on each edge with rst_n=1, ex_branch_taken=0, pc_write=0.
  - flush_cnt increments on each edge with rst_n=1, ex_branch_taken=1.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and logic are absent. Functional behaviour is otherwise identical.

Decomposition:
- Shared package core_pkg holds:
  - REG_ADDR_W=3 and the field bit positions (RD_MSB/LSB, RS1_MSB/LSB, RS2_MSB/LSB).
  - NOP_INSTR default and INSTR_WIDTH.
  - An instr_t typedef.
- One natural sub-module: pc_reg (PC register with hold, redirect, increment).
- The IF/ID register and field slicing stay in if_id_stage.

Test Plan:
- Reset with imem returning 16'h1234 -> pc=0, if_id_valid=0, if_id_instr=0, rs1=rs2=rd=0. First edge after release -> if_id_instr=16'h1234, if_id_pc=0, pc=1.
- Free run 4 cycles, imem[n]=16'h1000+n -> if_id_pc steps 0..3 and if_id_instr matches. Instr 16'h0A58 decodes rd=5, rs1=1, rs2=3.
- pc_write=if_id_write=0 for 2 cycles at pc=3 -> pc stays 3 and the IF/ID contents are unchanged. On release, pc=4 the following edge.
- ex_branch_taken=1, target=8'h40, during an active stall -> pc=8'h40, if_id_valid=0, if_id_instr=0. Next edge -> if_id_pc=8'h40, pc=8'h41.
- pc=8'hFF free run -> pc=8'h00 next edge, and if_id_pc=8'hFF.
- rst_n=0 during a stall with pc=7 -> all reset values on that edge. With IF_PERF_CNT_EN defined, 3 stall cycles then 1 redirect -> stall_cnt=3, flush_cnt=1.
